// File: rtl/ls_rs_if.sv
// Handshake bundle between dispatch, the CDB, the load/store reservation station and the LS unit.
// The master side is the surrounding pipeline; the slave side is the station itself.
interface ls_rs_if;
  logic        valid_dis2rs;
  logic [6:0]  opcode_dis2rs;
  logic [5:0]  tag_dis2rs;
  logic [5:0]  rd_dis2rs;
  logic [11:0] imm_dis2rs;
  logic [63:0] rs1_val_dis2rs;
  logic [5:0]  rs1_tag_dis2rs;
  logic        rs1_rdy_dis2rs;
  logic [63:0] rs2_val_dis2rs;
  logic [5:0]  rs2_tag_dis2rs;
  logic        rs2_rdy_dis2rs;
  logic        stop_rs2dis;

  logic        valid_cdb;
  logic [5:0]  tag_cdb;
  logic [63:0] result_cdb;

  logic        valid_rs2ls;
  logic [6:0]  opcode_rs2ls;
  logic [5:0]  tag_rs2ls;
  logic [63:0] rs1_rs2ls;
  logic [63:0] rs2_rs2ls;
  logic [5:0]  rd_rs2ls;
  logic [11:0] imm_rs2ls;
  logic        stop_ls2rsls;

  modport master (
    output valid_dis2rs, opcode_dis2rs, tag_dis2rs, rd_dis2rs, imm_dis2rs,
           rs1_val_dis2rs, rs1_tag_dis2rs, rs1_rdy_dis2rs,
           rs2_val_dis2rs, rs2_tag_dis2rs, rs2_rdy_dis2rs,
           valid_cdb, tag_cdb, result_cdb, stop_ls2rsls,
    input  stop_rs2dis, valid_rs2ls, opcode_rs2ls, tag_rs2ls,
           rs1_rs2ls, rs2_rs2ls, rd_rs2ls, imm_rs2ls
  );

  modport slave (
    input  valid_dis2rs, opcode_dis2rs, tag_dis2rs, rd_dis2rs, imm_dis2rs,
           rs1_val_dis2rs, rs1_tag_dis2rs, rs1_rdy_dis2rs,
           rs2_val_dis2rs, rs2_tag_dis2rs, rs2_rdy_dis2rs,
           valid_cdb, tag_cdb, result_cdb, stop_ls2rsls,
    output stop_rs2dis, valid_rs2ls, opcode_rs2ls, tag_rs2ls,
           rs1_rs2ls, rs2_rs2ls, rd_rs2ls, imm_rs2ls
  );
endinterface

// File: rtl/ls_reservation_station.sv
// In-order load/store reservation station: a circular buffer that snoops the CDB for
// missing operands and issues strictly from the head, so memory operations never reorder.
module ls_reservation_station #(
  parameter int         DEPTH     = 4,
  parameter logic [6:0] SD_OPCODE = 7'b0100011
) (
  input logic   clk,
  input logic   res_n,
  ls_rs_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [5:0]  tag;
    logic [5:0]  rd;
    logic [11:0] imm;
    logic [63:0] rs1_val;
    logic [5:0]  rs1_tag;
    logic        rs1_rdy;
    logic [63:0] rs2_val;
    logic [5:0]  rs2_tag;
    logic        rs2_rdy;
  } entry_t;

  entry_t           slots [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;

  entry_t head_slot;
  entry_t incoming;
  logic   full;
  logic   dispatch;
  logic   issue;

  always_comb begin
    full      = (count == (PW+1)'(DEPTH));
    head_slot = slots[head];

    bus.stop_rs2dis  = full;
    bus.valid_rs2ls  = (count != '0) && head_slot.rs1_rdy && head_slot.rs2_rdy;
    bus.opcode_rs2ls = head_slot.opcode;
    bus.tag_rs2ls    = head_slot.tag;
    bus.rs1_rs2ls    = head_slot.rs1_val;
    bus.rs2_rs2ls    = head_slot.rs2_val;
    bus.rd_rs2ls     = head_slot.rd;
    bus.imm_rs2ls    = head_slot.imm;

    dispatch = bus.valid_dis2rs && !full;
    issue    = bus.valid_rs2ls && !bus.stop_ls2rsls;
  end

  // Loads have no rs2 operand, and an operand produced on the CDB this very cycle is
  // forwarded into the new entry so it does not miss the broadcast.
  always_comb begin
    incoming.opcode  = bus.opcode_dis2rs;
    incoming.tag     = bus.tag_dis2rs;
    incoming.rd      = bus.rd_dis2rs;
    incoming.imm     = bus.imm_dis2rs;
    incoming.rs1_val = bus.rs1_val_dis2rs;
    incoming.rs1_tag = bus.rs1_tag_dis2rs;
    incoming.rs1_rdy = bus.rs1_rdy_dis2rs;
    incoming.rs2_val = bus.rs2_val_dis2rs;
    incoming.rs2_tag = bus.rs2_tag_dis2rs;
    incoming.rs2_rdy = bus.rs2_rdy_dis2rs || (bus.opcode_dis2rs != SD_OPCODE);
    if (!incoming.rs1_rdy && bus.valid_cdb && (incoming.rs1_tag == bus.tag_cdb)) begin
      incoming.rs1_val = bus.result_cdb;
      incoming.rs1_rdy = 1'b1;
    end
    if (!incoming.rs2_rdy && bus.valid_cdb && (incoming.rs2_tag == bus.tag_cdb)) begin
      incoming.rs2_val = bus.result_cdb;
      incoming.rs2_rdy = 1'b1;
    end
  end

  // Payload storage carries no reset; only the valid bits decide which slots matter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && bus.valid_cdb) begin
        if (!slots[i].rs1_rdy && (slots[i].rs1_tag == bus.tag_cdb)) begin
          slots[i].rs1_val <= bus.result_cdb;
          slots[i].rs1_rdy <= 1'b1;
        end
        if (!slots[i].rs2_rdy && (slots[i].rs2_tag == bus.tag_cdb)) begin
          slots[i].rs2_val <= bus.result_cdb;
          slots[i].rs2_rdy <= 1'b1;
        end
      end
    end
    if (dispatch) begin
      slots[tail] <= incoming;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      slot_valid <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      if (dispatch) begin
        slot_valid[tail] <= 1'b1;
        tail             <= tail + 1'b1;
      end
      if (issue) begin
        slot_valid[head] <= 1'b0;
        head             <= head + 1'b1;
      end
      case ({dispatch, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ls_reservation_station.sv
// Directed bench for ls_reservation_station: a queue-based reference model checked every
// cycle, plus literal expectations on issue order, wakeup latency and reset behaviour.
module tb_ls_reservation_station;
  localparam int         DEPTH = 4;
  localparam logic [6:0] SD_OP = 7'b0100011;
  localparam logic [6:0] LD_OP = 7'b0000011;

  logic clk;
  logic res_n;
  ls_rs_if bus ();

  ls_reservation_station #(.DEPTH(DEPTH), .SD_OPCODE(SD_OP)) dut (
    .clk  (clk),
    .res_n(res_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [5:0]  tag;
    logic [5:0]  rd;
    logic [11:0] imm;
    logic [63:0] v1;
    logic [5:0]  t1;
    logic        r1;
    logic [63:0] v2;
    logic [5:0]  t2;
    logic        r2;
  } model_entry_t;

  model_entry_t model_q[$];
  int           issue_log[$];
  int           vectors = 0;
  int           miscompares = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: stations is a FIFO list; decisions use the state at the start of the cycle.
  task automatic model_step();
    model_entry_t ne;
    bit           head_goes;
    bit           was_full;
    if (!res_n) return;
    was_full  = (model_q.size() == DEPTH);
    head_goes = (model_q.size() > 0) && model_q[0].r1 && model_q[0].r2 && !bus.stop_ls2rsls;
    ne.op  = bus.opcode_dis2rs;  ne.tag = bus.tag_dis2rs;  ne.rd = bus.rd_dis2rs;
    ne.imm = bus.imm_dis2rs;
    ne.v1  = bus.rs1_val_dis2rs; ne.t1 = bus.rs1_tag_dis2rs; ne.r1 = bus.rs1_rdy_dis2rs;
    ne.v2  = bus.rs2_val_dis2rs; ne.t2 = bus.rs2_tag_dis2rs;
    ne.r2  = bus.rs2_rdy_dis2rs || (bus.opcode_dis2rs != SD_OP);
    if (bus.valid_cdb) begin
      if (!ne.r1 && ne.t1 == bus.tag_cdb) begin ne.r1 = 1'b1; ne.v1 = bus.result_cdb; end
      if (!ne.r2 && ne.t2 == bus.tag_cdb) begin ne.r2 = 1'b1; ne.v2 = bus.result_cdb; end
      foreach (model_q[i]) begin
        if (!model_q[i].r1 && model_q[i].t1 == bus.tag_cdb) begin model_q[i].r1 = 1'b1; model_q[i].v1 = bus.result_cdb; end
        if (!model_q[i].r2 && model_q[i].t2 == bus.tag_cdb) begin model_q[i].r2 = 1'b1; model_q[i].v2 = bus.result_cdb; end
      end
    end
    if (head_goes) void'(model_q.pop_front());
    if (bus.valid_dis2rs && !was_full) model_q.push_back(ne);
  endtask

  task automatic compare_model();
    bit exp_valid;
    exp_valid = (model_q.size() > 0) && model_q[0].r1 && model_q[0].r2;
    check_output("valid_rs2ls", 64'(bus.valid_rs2ls), 64'(exp_valid));
    check_output("stop_rs2dis", 64'(bus.stop_rs2dis), 64'(model_q.size() == DEPTH));
    if (exp_valid) begin
      check_output("opcode_rs2ls", 64'(bus.opcode_rs2ls), 64'(model_q[0].op));
      check_output("tag_rs2ls", 64'(bus.tag_rs2ls), 64'(model_q[0].tag));
      check_output("rd_rs2ls", 64'(bus.rd_rs2ls), 64'(model_q[0].rd));
      check_output("imm_rs2ls", 64'(bus.imm_rs2ls), 64'(model_q[0].imm));
      check_output("rs1_rs2ls", bus.rs1_rs2ls, model_q[0].v1);
      check_output("rs2_rs2ls", bus.rs2_rs2ls, model_q[0].v2);
    end
  endtask

  // One clock: model and issue log advance on the inputs as driven, DUT is checked mid-cycle.
  task automatic tick();
    if (res_n && bus.valid_rs2ls && !bus.stop_ls2rsls) issue_log.push_back(int'(bus.tag_rs2ls));
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
    #1;
  endtask

  task automatic clear_inputs();
    bus.valid_dis2rs = 1'b0;
    bus.valid_cdb    = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [6:0] op, input logic [5:0] tag, input logic [11:0] imm,
                                input logic [63:0] v1, input logic [5:0] t1, input logic r1,
                                input logic [63:0] v2, input logic [5:0] t2, input logic r2);
    bus.valid_dis2rs   = 1'b1;
    bus.opcode_dis2rs  = op;
    bus.tag_dis2rs     = tag;
    bus.rd_dis2rs      = tag + 6'd10;
    bus.imm_dis2rs     = imm;
    bus.rs1_val_dis2rs = v1;
    bus.rs1_tag_dis2rs = t1;
    bus.rs1_rdy_dis2rs = r1;
    bus.rs2_val_dis2rs = v2;
    bus.rs2_tag_dis2rs = t2;
    bus.rs2_rdy_dis2rs = r2;
  endtask

  task automatic broadcast(input logic [5:0] tag, input logic [63:0] value);
    bus.valid_cdb  = 1'b1;
    bus.tag_cdb    = tag;
    bus.result_cdb = value;
  endtask

  task automatic check_log(input string name, input int expected[$]);
    check_output({name, "_count"}, 64'(issue_log.size()), 64'(expected.size()));
    foreach (expected[i])
      check_output(name, (i < issue_log.size()) ? 64'(issue_log[i]) : 64'hFFFF, 64'(expected[i]));
  endtask

  initial begin
    res_n = 1'b0;
    bus.stop_ls2rsls = 1'b0;
    bus.tag_cdb = '0;
    bus.result_cdb = '0;
    apply_stimulus(LD_OP, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_inputs();
    @(negedge clk); #1;
    repeat (2) tick();
    check_output("reset_valid", 64'(bus.valid_rs2ls), 64'd0);
    check_output("reset_stop", 64'(bus.stop_rs2dis), 64'd0);
    res_n = 1'b1;

    // Ready load issues the cycle after dispatch, then drains.
    apply_stimulus(LD_OP, 6'd5, 12'd8, 64'h100, 0, 1'b1, 0, 6'd33, 1'b0);
    tick(); clear_inputs();
    check_output("t1_valid", 64'(bus.valid_rs2ls), 64'd1);
    check_output("t1_tag", 64'(bus.tag_rs2ls), 64'd5);
    check_output("t1_rs1", bus.rs1_rs2ls, 64'h100);
    check_output("t1_imm", 64'(bus.imm_rs2ls), 64'd8);
    tick();
    check_output("t1_drained", 64'(bus.valid_rs2ls), 64'd0);

    // Store waits on rs2 until tag 9 appears on the CDB.
    apply_stimulus(SD_OP, 6'd3, 12'd4, 64'h10, 0, 1'b1, 0, 6'd9, 1'b0);
    tick(); clear_inputs();
    check_output("t2_wait", 64'(bus.valid_rs2ls), 64'd0);
    broadcast(6'd9, 64'hDEAD);
    tick(); clear_inputs();
    check_output("t2_woken", 64'(bus.valid_rs2ls), 64'd1);
    check_output("t2_rs2", bus.rs2_rs2ls, 64'hDEAD);
    tick();

    // Operand broadcast in the same cycle as dispatch is captured on write.
    apply_stimulus(LD_OP, 6'd4, 12'd0, 0, 6'd7, 1'b0, 0, 0, 1'b0);
    broadcast(6'd7, 64'h42);
    tick(); clear_inputs();
    check_output("t3_valid", 64'(bus.valid_rs2ls), 64'd1);
    check_output("t3_rs1", bus.rs1_rs2ls, 64'h42);
    tick();

    // Fill under stop, overflow dispatch is dropped, then drain in order.
    bus.stop_ls2rsls = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      apply_stimulus(LD_OP, 6'(t), 12'(t), 64'(t * 16), 0, 1'b1, 0, 0, 1'b1);
      tick();
    end
    clear_inputs();
    check_output("t4_full", 64'(bus.stop_rs2dis), 64'd1);
    apply_stimulus(LD_OP, 6'd5, 12'd5, 64'h50, 0, 1'b1, 0, 0, 1'b1);
    tick(); clear_inputs();
    check_output("t4_held_tag", 64'(bus.tag_rs2ls), 64'd1);
    issue_log.delete();
    bus.stop_ls2rsls = 1'b0;
    tick();
    check_output("t4_stop_fall", 64'(bus.stop_rs2dis), 64'd0);
    repeat (3) tick();
    check_log("t4_order", '{1, 2, 3, 4});
    check_output("t4_empty", 64'(bus.valid_rs2ls), 64'd0);

    // A ready younger entry waits behind a blocked head.
    issue_log.delete();
    apply_stimulus(LD_OP, 6'd1, 12'd0, 0, 6'd20, 1'b0, 0, 0, 1'b0);
    tick();
    apply_stimulus(LD_OP, 6'd2, 12'd0, 64'h22, 0, 1'b1, 0, 0, 1'b0);
    tick(); clear_inputs();
    tick();
    check_output("t5_blocked", 64'(bus.valid_rs2ls), 64'd0);
    broadcast(6'd20, 64'h77);
    tick(); clear_inputs();
    check_output("t5_head_tag", 64'(bus.tag_rs2ls), 64'd1);
    repeat (2) tick();
    check_log("t5_order", '{1, 2});

    // Asynchronous reset mid-cycle with the station full.
    bus.stop_ls2rsls = 1'b1;
    for (int t = 0; t < 4; t++) begin
      apply_stimulus(LD_OP, 6'(40 + t), 12'd0, 64'(t), 0, 1'b1, 0, 0, 1'b1);
      tick();
    end
    clear_inputs();
    #2;
    res_n = 1'b0;
    model_q.delete();
    #1;
    check_output("t6_async_valid", 64'(bus.valid_rs2ls), 64'd0);
    check_output("t6_async_stop", 64'(bus.stop_rs2dis), 64'd0);
    tick();
    res_n = 1'b1;
    bus.stop_ls2rsls = 1'b0;
    issue_log.delete();
    repeat (3) tick();
    check_output("t6_no_stale", 64'(issue_log.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
